// File: rtl/stall_ctrl_pkg.sv
// rtl/stall_ctrl_pkg.sv - shared encodings, defaults and hazard helper for stall_ctrl
package stall_ctrl_pkg;

    localparam logic [1:0] TUSE_NONE        = 2'd3;
    localparam int         MULT_CYCLES_DEF  = 5;
    localparam int         DIV_CYCLES_DEF   = 10;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // A source in D must wait if a pending writer of the same register
    // produces its value later than D consumes it; $0 never conflicts.
    function automatic logic src_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] e_a3,
        input logic [1:0] e_tnew,
        input logic [4:0] m_a3,
        input logic [1:0] m_tnew
    );
        return (src != 5'd0) &&
               (((src == e_a3) && (tuse < e_tnew)) ||
                ((src == m_a3) && (tuse < m_tnew)));
    endfunction

endpackage

// File: rtl/stall_ctrl_if.sv
// rtl/stall_ctrl_if.sv - pipeline hazard inputs and stall outputs of stall_ctrl
interface stall_ctrl_if;
    logic [4:0]  D_rs;
    logic [4:0]  D_rt;
    logic [1:0]  D_Tuse_rs;
    logic [1:0]  D_Tuse_rt;
    logic [4:0]  E_A3;
    logic [4:0]  M_A3;
    logic [1:0]  E_Tnew;
    logic [1:0]  M_Tnew;
    logic        D_is_md;
    logic        E_md_start;
    logic        E_md_div;
    logic        PC_WrEn;
    logic        FD_WrEn;
    logic        DE_flush;
    logic        md_busy;
    logic [3:0]  md_cnt;
    logic [31:0] stall_cnt;

    modport master (
        output D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, E_A3, M_A3, E_Tnew, M_Tnew,
        output D_is_md, E_md_start, E_md_div,
        input  PC_WrEn, FD_WrEn, DE_flush, md_busy, md_cnt, stall_cnt
    );

    modport slave (
        input  D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, E_A3, M_A3, E_Tnew, M_Tnew,
        input  D_is_md, E_md_start, E_md_div,
        output PC_WrEn, FD_WrEn, DE_flush, md_busy, md_cnt, stall_cnt
    );
endinterface

// File: rtl/stall_ctrl_md_timer.sv
// rtl/stall_ctrl_md_timer.sv - busy timer modelling the multi-cycle mult/div unit
module md_timer
    import stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_i,
    input  logic       div_i,
    output logic       md_busy_o,
    output logic [3:0] md_cnt_o
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    md_state_t  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A start seen while busy is dropped; the D-stage stall keeps it from happening.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_IDLE: begin
                if (start_i) begin
                    state_d = MD_BUSY;
                    cnt_d   = div_i ? DIV_LOAD : MULT_LOAD;
                end
            end
            MD_BUSY: begin
                if (cnt_q == 4'd1) begin
                    state_d = MD_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_comb begin
        md_busy_o = (state_q == MD_BUSY);
        md_cnt_o  = cnt_q;
    end

endmodule

// File: rtl/stall_ctrl.sv
// rtl/stall_ctrl.sv - D-stage stall generation from register and mult/div hazards
module stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic         clk,
    input  logic         reset,
    stall_ctrl_if.slave  bus
);

    logic        hz_rs, hz_rt, hz_md, stall;
    logic        md_busy;
    logic [3:0]  md_cnt;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    md_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_timer (
        .clk       (clk),
        .reset     (reset),
        .start_i   (bus.E_md_start),
        .div_i     (bus.E_md_div),
        .md_busy_o (md_busy),
        .md_cnt_o  (md_cnt)
    );

    // Purely combinational so the stall takes effect in the same cycle, even under reset.
    always_comb begin
        hz_rs = src_hazard(bus.D_rs, bus.D_Tuse_rs, bus.E_A3, bus.E_Tnew, bus.M_A3, bus.M_Tnew);
        hz_rt = src_hazard(bus.D_rt, bus.D_Tuse_rt, bus.E_A3, bus.E_Tnew, bus.M_A3, bus.M_Tnew);
        hz_md = bus.D_is_md & (md_busy | bus.E_md_start);
        stall = hz_rs | hz_rt | hz_md;
    end

    always_comb begin
        stall_cnt_d = stall ? stall_cnt_q + 32'd1 : stall_cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.PC_WrEn   = ~stall;
    assign bus.FD_WrEn   = ~stall;
    assign bus.DE_flush  = stall;
    assign bus.md_busy   = md_busy;
    assign bus.md_cnt    = md_cnt;
    assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_stall_ctrl.sv
// tb/tb_stall_ctrl.sv - directed vector and sequence bench for stall_ctrl
module tb_stall_ctrl;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;
    logic [31:0] exp_cnt;

    stall_ctrl_if bus();

    stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] tuse_rs;
        logic [1:0] tuse_rt;
        logic [4:0] e_a3;
        logic [1:0] e_tnew;
        logic [4:0] m_a3;
        logic [1:0] m_tnew;
        logic       exp_stall;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        bus.D_rs = 5'd0;       bus.D_rt = 5'd0;
        bus.D_Tuse_rs = 2'd3;  bus.D_Tuse_rt = 2'd3;
        bus.E_A3 = 5'd0;       bus.M_A3 = 5'd0;
        bus.E_Tnew = 2'd0;     bus.M_Tnew = 2'd0;
        bus.D_is_md = 1'b0;    bus.E_md_start = 1'b0;
        bus.E_md_div = 1'b0;
    endtask

    task automatic set_load_use();
        bus.D_rs = 5'd5; bus.D_Tuse_rs = 2'd0; bus.E_A3 = 5'd5; bus.E_Tnew = 2'd2;
    endtask

    initial begin
        int busy_n;
        n_checks = 0;
        n_pass   = 0;
        exp_cnt  = 32'd0;

        //            rs  rt  tu_rs tu_rt eA3 eTn mA3 mTn stall
        vecs[0] = '{5'd5, 5'd0, 2'd0, 2'd3, 5'd5, 2'd2, 5'd0, 2'd0, 1'b1};
        vecs[1] = '{5'd5, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 5'd5, 2'd1, 1'b1};
        vecs[2] = '{5'd5, 5'd0, 2'd0, 2'd3, 5'd0, 2'd0, 5'd5, 2'd0, 1'b0};
        vecs[3] = '{5'd0, 5'd0, 2'd0, 2'd3, 5'd0, 2'd2, 5'd0, 2'd0, 1'b0};
        vecs[4] = '{5'd0, 5'd7, 2'd3, 2'd1, 5'd7, 2'd2, 5'd0, 2'd0, 1'b1};
        vecs[5] = '{5'd0, 5'd7, 2'd3, 2'd2, 5'd7, 2'd2, 5'd0, 2'd0, 1'b0};
        vecs[6] = '{5'd3, 5'd0, 2'd3, 2'd3, 5'd3, 2'd3, 5'd3, 2'd3, 1'b0};
        vecs[7] = '{5'd9, 5'd0, 2'd1, 2'd3, 5'd10, 2'd2, 5'd9, 2'd2, 1'b1};
        vecs[8] = '{5'd9, 5'd8, 2'd0, 2'd0, 5'd10, 2'd2, 5'd11, 2'd2, 1'b0};
        vecs[9] = '{5'd4, 5'd0, 2'd1, 2'd3, 5'd4, 2'd1, 5'd0, 2'd0, 1'b0};

        reset = 1'b0;
        clr_inputs();
        #2 reset = 1'b1;
        #1 set_load_use();
        #1;
        chk("rst_md_busy", {31'd0, bus.md_busy}, 32'd0);
        chk("rst_stall_cnt", bus.stall_cnt, 32'd0);
        chk("rst_comb_flush", {29'd0, bus.PC_WrEn, bus.FD_WrEn, bus.DE_flush}, 32'b001);
        step();
        step();
        chk("rst_cnt_held", bus.stall_cnt, 32'd0);
        reset = 1'b0;
        clr_inputs();
        #1;

        for (int i = 0; i < 10; i++) begin
            bus.D_rs = vecs[i].rs;           bus.D_rt = vecs[i].rt;
            bus.D_Tuse_rs = vecs[i].tuse_rs; bus.D_Tuse_rt = vecs[i].tuse_rt;
            bus.E_A3 = vecs[i].e_a3;         bus.E_Tnew = vecs[i].e_tnew;
            bus.M_A3 = vecs[i].m_a3;         bus.M_Tnew = vecs[i].m_tnew;
            #1;
            chk($sformatf("vec%0d_ctrl", i), {29'd0, bus.PC_WrEn, bus.FD_WrEn, bus.DE_flush},
                {29'd0, ~vecs[i].exp_stall, ~vecs[i].exp_stall, vecs[i].exp_stall});
            step();
            if (vecs[i].exp_stall) exp_cnt = exp_cnt + 32'd1;
            chk($sformatf("vec%0d_cnt", i), bus.stall_cnt, exp_cnt);
        end
        clr_inputs();

        // mult with D_is_md held: stall on start cycle plus 5 busy cycles
        bus.E_md_start = 1'b1; bus.E_md_div = 1'b0; bus.D_is_md = 1'b1;
        #1 chk("mult_start_stall", {31'd0, bus.DE_flush}, 32'd1);
        step();
        exp_cnt = exp_cnt + 32'd1;
        bus.E_md_start = 1'b0;
        #1 chk("mult_load", {28'd0, bus.md_cnt}, 32'd5);
        for (int k = 1; k <= 6; k++) begin
            chk($sformatf("mult_busy_t%0d", k), {30'd0, bus.md_busy, bus.DE_flush},
                (k <= 5) ? 32'b11 : 32'b00);
            if (k <= 5) exp_cnt = exp_cnt + 32'd1;
            step();
        end
        chk("mult_stall_cnt", bus.stall_cnt, exp_cnt);
        chk("mult_cnt_zero", {28'd0, bus.md_cnt}, 32'd0);
        clr_inputs();

        // non-md instruction proceeds while the unit is busy
        bus.E_md_start = 1'b1;
        #1 chk("nc_start_nostall", {31'd0, bus.DE_flush}, 32'd0);
        step();
        bus.E_md_start = 1'b0;
        #1;
        for (int k = 1; k <= 5; k++) begin
            chk($sformatf("nc_busy_t%0d", k),
                {28'd0, bus.md_busy, bus.PC_WrEn, bus.FD_WrEn, bus.DE_flush}, 32'b1110);
            step();
        end
        chk("nc_stall_cnt", bus.stall_cnt, exp_cnt);
        chk("nc_idle", {31'd0, bus.md_busy}, 32'd0);

        // register hazard overlapping an md stall counts once
        bus.E_md_start = 1'b1;
        step();
        bus.E_md_start = 1'b0;
        bus.D_is_md = 1'b1;
        set_load_use();
        #1 chk("ovl_stall", {31'd0, bus.DE_flush}, 32'd1);
        step();
        exp_cnt = exp_cnt + 32'd1;
        chk("ovl_cnt", bus.stall_cnt, exp_cnt);
        clr_inputs();
        for (int k = 0; k < 10 && bus.md_busy; k++) step();
        chk("ovl_drain", {31'd0, bus.md_busy}, 32'd0);

        // div busy length
        bus.E_md_start = 1'b1; bus.E_md_div = 1'b1;
        step();
        bus.E_md_start = 1'b0; bus.E_md_div = 1'b0;
        #1 chk("div_load", {28'd0, bus.md_cnt}, 32'd10);
        busy_n = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.md_busy) busy_n++;
            step();
        end
        chk("div_busy_len", busy_n, 32'd10);

        // async reset at the fourth busy cycle of a div
        bus.E_md_start = 1'b1; bus.E_md_div = 1'b1;
        step();
        bus.E_md_start = 1'b0; bus.E_md_div = 1'b0;
        step(); step(); step();
        chk("divrst_busy4", {31'd0, bus.md_busy}, 32'd1);
        chk("divrst_cnt_before", bus.stall_cnt, exp_cnt);
        set_load_use();
        #2 reset = 1'b1;
        #1;
        chk("divrst_busy_now", {31'd0, bus.md_busy}, 32'd0);
        chk("divrst_cnt_now", bus.stall_cnt, 32'd0);
        chk("divrst_mdcnt_now", {28'd0, bus.md_cnt}, 32'd0);
        chk("divrst_comb", {29'd0, bus.PC_WrEn, bus.FD_WrEn, bus.DE_flush}, 32'b001);
        step();
        reset = 1'b0;
        clr_inputs();
        step();
        chk("divrst_idle_after", {31'd0, bus.md_busy}, 32'd0);
        chk("divrst_cnt_after", bus.stall_cnt, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
